// File: rtl/multdiv_pkg.sv
// ----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the iterative multiply/divide sequencer.
//   state_t        : sequencer states (IDLE, LOAD, ITER, DONE)
//   ITERS_DEFAULT  : iterations per operation, one per operand bit
//   OP_MULT/OP_DIV : encoding of the op-type register / op_is_div output
// ----------------------------------------------------------------------------
package multdiv_pkg;

    localparam int ITERS_DEFAULT = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ITER = 2'b10,
        DONE = 2'b11
    } state_t;

endpackage

// File: rtl/iter_counter.sv
// ----------------------------------------------------------------------------
// iter_counter
// Iteration index counter for the multiply/divide sequencer.
//   clock        : rising-edge clock
//   ctrl_reset_n : asynchronous active-low reset, count -> 0
//   clr          : synchronous clear (has priority over en)
//   en           : increment by one (modulo 2^CNT_W)
//   count        : current iteration index
//   last         : high when count == ITERS-1
// ----------------------------------------------------------------------------
module iter_counter #(
    parameter int ITERS = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ITERS - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Clear wins over enable so a restart during ITER always lands on 0.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/multdiv_seq.sv
// ----------------------------------------------------------------------------
// multdiv_seq
// Sequencer for the iterative multiply/divide unit. Turns the one-cycle
// start pulses from execute into load/clear/iterate enables for the
// falling-edge datapath registers and returns a one-cycle completion pulse.
//   clock        : rising-edge clock (datapath captures on the falling edge)
//   ctrl_reset_n : asynchronous active-low reset
//   ctrl_MULT    : multiply start pulse (wins if both pulses are high)
//   ctrl_DIV     : divide start pulse
//   divisor_zero : divisor == 0 from the datapath, looked at only in LOAD
//   op_load_en   : operand register enable (combinational from the pulses)
//   acc_clr      : clear accumulator/remainder register
//   iter_en      : one shift/add or shift/subtract step
//   op_is_div    : selects the divide datapath for the whole operation
//   iter_count   : current iteration index
//   busy         : operation in progress (LOAD, ITER, DONE)
//   result_rdy   : one-cycle completion pulse
//   exception    : divide-by-zero, qualified by result_rdy
// ----------------------------------------------------------------------------
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int ITERS = ITERS_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic             divisor_zero,
    output logic             op_load_en,
    output logic             acc_clr,
    output logic             iter_en,
    output logic             op_is_div,
    output logic [CNT_W-1:0] iter_count,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
);

    state_t state;
    state_t state_next;

    logic start;
    logic op_div_q;
    logic exc_q;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_last;

    assign start = ctrl_MULT | ctrl_DIV;

    // The count is zeroed both by the start pulse itself (so a restart shows
    // 0 already in its LOAD cycle) and during LOAD. Incrementing stops on the
    // last index so the count never wraps.
    assign cnt_clr = start | (state == LOAD);
    assign cnt_en  = (state == ITER) & ~cnt_last;

    iter_counter #(
        .ITERS (ITERS),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .clr          (cnt_clr),
        .en           (cnt_en),
        .count        (iter_count),
        .last         (cnt_last)
    );

    // State register.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Op type is captured on every accepted start; MULT has priority when
    // both pulses arrive together.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            op_div_q <= OP_MULT;
        end else if (start) begin
            op_div_q <= ctrl_MULT ? OP_MULT : OP_DIV;
        end
    end

    // Divide-by-zero flag: set from LOAD, dropped when DONE is left or when
    // a new start aborts whatever was in flight.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            exc_q <= 1'b0;
        end else if (start) begin
            exc_q <= 1'b0;
        end else if ((state == LOAD) && op_div_q && divisor_zero) begin
            exc_q <= 1'b1;
        end else if (state == DONE) begin
            exc_q <= 1'b0;
        end
    end

    // Next state and output decode. A start in any state goes to LOAD; in
    // DONE the current result_rdy still goes out since it is the old op's.
    always_comb begin
        state_next = state;
        op_load_en = start;
        acc_clr    = 1'b0;
        iter_en    = 1'b0;
        busy       = 1'b1;
        result_rdy = 1'b0;
        exception  = 1'b0;
        op_is_div  = op_div_q;

        case (state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                acc_clr = 1'b1;
                if (op_div_q && divisor_zero) begin
                    state_next = DONE;
                end else begin
                    state_next = ITER;
                end
            end
            ITER: begin
                iter_en = 1'b1;
                if (cnt_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                result_rdy = 1'b1;
                exception  = exc_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (start) begin
            state_next = LOAD;
        end
    end

endmodule
